dm_mc: RTL and testbench
========================

# dm_mc

Parametrised multi-cycle data memory for the pipelined CPU's MEM stage. It accepts one load or store per request and completes it after a configurable number of cycles, signalling `busy` so the pipeline can stall. Stores merge byte and halfword lanes into the existing word. Loads return the selected lane sign- or zero-extended. Misaligned, reserved-size and out-of-range requests are rejected with an exception flag instead of touching memory.

## Interface
- `AW`, default 12: word-address width; capacity is 2^AW 32-bit words.
- `LATENCY`, default 2: cycles from request acceptance to `done`; legal range 1..15.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req` input, 1 bit: access request; sampled only when the block can accept (see Operation).
- `wr` input, 1 bit: 1 = store, 0 = load.
- `addr` input, 32 bits: byte address.
- `size` input, 2 bits: access size; 00 byte, 01 half, 10 word, 11 reserved.
- `ext` input, 1 bit: loads only; 1 = sign-extend, 0 = zero-extend.
- `wd` input, 32 bits: store data; the lane is taken from the LSBs (`wd[7:0]` for byte, `wd[15:0]` for half).
- `busy` output, 1 bit: an access is in flight and cannot accept.
- `done` output, 1 bit: one-cycle completion pulse.
- `rd` output, 32 bits: load result; valid while `done` is high and held until the next load completes.
- `exc` output, 1 bit: qualifies `done`; 1 = the access was rejected.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Acceptance: `req`=1 is accepted in the IDLE or DONE state. `wr`, `addr`, `size`, `ext` and `wd` are latched at that edge.
- `req` is ignored while in WAIT; the requester holds it until acceptance.
- Rejection check at acceptance:
  - `size`=11 is rejected.
  - half with `addr[0]`=1 is rejected.
  - word with `addr[1:0]`≠0 is rejected.
  - `addr[31:2]` ≥ 2^AW is rejected.
- Rejected access: go straight to DONE on the next edge with `exc`=1. No memory write; `rd` is unchanged.
- Valid access, LATENCY=1: go straight to DONE.
- Valid access, LATENCY>1: enter WAIT, load a down-counter with LATENCY-2, and move to DONE when the counter reaches 0.
- Store: the write happens at the edge that enters DONE.
  - Only the addressed lanes change: byte lane = `addr[1:0]`; half lane = `addr[1]` (lower or upper half).
  - All other bytes keep their previous value (read-modify-write; lanes are not zeroed).
- Load: `rd` is registered at the edge entering DONE.
  - Byte: `mem[addr[1:0]*8 +: 8]`, extended to 32 bits per `ext`.
  - Half: the selected half, extended to 32 bits per `ext`.
  - Word: returned as-is.
- From DONE: if `req`=1, accept (back-to-back); otherwise go to IDLE.
- Memory is zero-initialised at time 0 and is not cleared by `rst`, so it can map to block RAM.

## Timing
- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `exc`=0, `rd`=0.
- `rst` mid-access aborts it: no write, no `done`, back to IDLE. `rst` has priority over `req` in the same cycle.
- `busy`=1 exactly in WAIT cycles. It is 0 in IDLE and DONE. With LATENCY=1 it is never 1.
- `done` and `exc` are high for exactly one cycle per accepted request.
- Valid access accepted at edge E0: `done`=1 in the cycle after edge E_LATENCY.
- Rejected access: `done`=1 in the cycle after edge E1, regardless of LATENCY.
- Throughput: one access per LATENCY cycles when `req` is held high. Back-to-back accepts happen from DONE.
- A load issued in the DONE cycle of a store to the same word sees the stored data, because the write has already committed.

## Test plan
- Reset, then idle for 5 cycles → `busy`=`done`=`exc`=0 and `rd`=0 throughout.
- LATENCY=2: `sw` 0x11223344 @0x10, then `sb` 0xAB @0x12 → reading word @0x10 returns 0x11AB3344.
  - Each `done` pulse arrives 2 cycles after acceptance; `busy` is high for 1 cycle per access.
- Loads from 0x10 holding 0x80FF7F01:
  - `lb` @0x13 (`ext`=1) → 0xFFFFFF80.
  - `lbu` @0x13 → 0x00000080.
  - `lh` @0x12 → 0xFFFF80FF.
  - `lhu` @0x10 → 0x00007F01.
- Rejection cases, each → `done`=`exc`=1 one cycle after acceptance, with no memory change:
  - `lw` @0x11.
  - `sh` @0x13.
  - `size`=11.
  - `addr`=0x4000 with AW=12.
- LATENCY=3 with `req` held high for 4 loads → exactly 4 `done` pulses, spaced 3 cycles apart. Toggling `req` during WAIT has no effect.
- `rst` asserted during WAIT of a `sw` @0x20 → no `done` pulse; a subsequent `lw` @0x20 returns the old value.

Source files
------------

// File: rtl/dm_mc.sv
// Multi-cycle data memory for the MEM stage: byte/half/word loads and stores
// with a programmable completion latency and rejection of illegal accesses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access in flight; accepts req
// S_WAIT | valid access in flight, down-counter running; busy high
// S_DONE | one-cycle completion (done, exc); also accepts req
module dm_mc #(
    parameter int AW      = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        ext,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        exc
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          exc_q, exc_n;
    logic [31:0]   rd_q;

    logic          wr_q, ext_q;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic [31:0]   wd_q;

    logic          accept, reject, commit, in_wait;
    logic          op_wr, op_ext;
    logic [AW+1:0] op_addr;
    logic [1:0]    op_size;
    logic [31:0]   op_wd;
    logic [AW-1:0] widx;
    logic [31:0]   old_word, merged, load_val;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    logic [31:0]   mem [DEPTH] = '{default: '0};

    assign accept = req && (state == S_IDLE || state == S_DONE);
    assign reject = (size == 2'b11)
                 || (size == 2'b01 && addr[0])
                 || (size == 2'b10 && addr[1:0] != 2'b00)
                 || ((addr >> (AW + 2)) != 32'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        exc_n   = exc_q;
        commit  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                exc_n = 1'b0;
                if (accept) begin
                    if (reject) begin
                        state_n = S_DONE;
                        exc_n   = 1'b1;
                    end else if (LATENCY == 1) begin
                        state_n = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = S_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Commit uses the latched request from WAIT, or the live inputs when the
    // access completes straight from acceptance (LATENCY == 1).
    assign in_wait = (state == S_WAIT);
    assign op_wr   = in_wait ? wr_q   : wr;
    assign op_ext  = in_wait ? ext_q  : ext;
    assign op_addr = in_wait ? addr_q : addr[AW+1:0];
    assign op_size = in_wait ? size_q : size;
    assign op_wd   = in_wait ? wd_q   : wd;

    assign widx     = op_addr[AW+1:2];
    assign old_word = mem[widx];
    assign byte_sel = old_word[{op_addr[1:0], 3'b000} +: 8];
    assign half_sel = old_word[{op_addr[1], 4'b0000} +: 16];

    always_comb begin
        merged   = old_word;
        load_val = old_word;
        case (op_size)
            2'b00: begin
                merged[{op_addr[1:0], 3'b000} +: 8] = op_wd[7:0];
                load_val = {{24{op_ext & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                merged[{op_addr[1], 4'b0000} +: 16] = op_wd[15:0];
                load_val = {{16{op_ext & half_sel[15]}}, half_sel};
            end
            default: merged = op_wd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            exc_q <= 1'b0;
            rd_q  <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            exc_q <= exc_n;
            if (commit && !op_wr) begin
                rd_q <= load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            wr_q   <= wr;
            ext_q  <= ext;
            addr_q <= addr[AW+1:0];
            size_q <= size;
            wd_q   <= wd;
        end
    end

    // No reset on the array so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_wr) begin
            mem[widx] <= merged;
        end
    end

    assign busy = (state == S_WAIT);
    assign done = (state == S_DONE);
    assign exc  = done && exc_q;
    assign rd   = rd_q;
endmodule

// File: tb/tb_dm_mc.sv
// Bench for dm_mc: two instances (LATENCY 2 and 3) driven with the same
// accesses, checked against directed vectors and a word-array reference model.
module tb_dm_mc;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req2 = 1'b0, req3 = 1'b0;
    logic        wr = 1'b0, ext = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [1:0]  size = 2'b10;
    logic        busy2, done2, exc2, busy3, done3, exc3;
    logic [31:0] rd2, rd3;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] mdl [1 << AW];
    logic [31:0] rd_last2 = '0, rd_last3 = '0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [1:0]  s;
        logic        e;
        logic [31:0] d;
        logic        x;
        logic [31:0] r;
    } vec_t;

    vec_t        tbl [20];
    logic [31:0] h_addr [4];
    logic [1:0]  h_size [4];
    logic        h_ext  [4];
    logic [31:0] h_rd   [4];

    logic        r_w, r_e, m_x;
    logic [1:0]  r_s;
    logic [31:0] r_a, r_d, m_r;
    int          dones;

    always #5 clk = ~clk;

    dm_mc #(.AW(AW), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .req(req2), .wr(wr), .addr(addr), .size(size),
        .ext(ext), .wd(wd), .busy(busy2), .done(done2), .rd(rd2), .exc(exc2)
    );

    dm_mc #(.AW(AW), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .req(req3), .wr(wr), .addr(addr), .size(size),
        .ext(ext), .wd(wd), .busy(busy3), .done(done3), .rd(rd3), .exc(exc3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Reference: memory as a word array, lanes handled by shift-and-mask.
    function automatic void model_op(input logic w, input logic [31:0] a, input logic [1:0] s,
                                     input logic e, input logic [31:0] d,
                                     output logic x, output logic [31:0] r);
        int unsigned wi, sh;
        logic [31:0] word, mask;
        x = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
            || ((a / 4) >= 32'(1 << AW));
        r = '0;
        if (x) return;
        wi   = a / 4;
        word = mdl[wi];
        if (s == 2'd0) begin
            sh = 32'(a[1:0]) * 8;
            mask = 32'hFF << sh;
        end else if (s == 2'd1) begin
            sh = 32'(a[1]) * 16;
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        if (w) begin
            mdl[wi] = (word & ~mask) | ((d << sh) & mask);
        end else begin
            r = (word & mask) >> sh;
            if (e && s == 2'd0 && r[7])  r = r | 32'hFFFF_FF00;
            if (e && s == 2'd1 && r[15]) r = r | 32'hFFFF_0000;
        end
    endfunction

    // One access issued to both instances, then six observed cycles.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic e, input logic [31:0] d,
                         input logic ex, input logic [31:0] er, input string nm);
        int dc2, dc3, bc2, bc3;
        logic x2, x3;
        logic [31:0] r2, r3, want2, want3;
        dc2 = -1; dc3 = -1; bc2 = 0; bc3 = 0;
        x2 = 1'bx; x3 = 1'bx; r2 = 32'hDEAD_BEEF; r3 = 32'hDEAD_BEEF;
        @(negedge clk);
        wr = w; addr = a; size = s; ext = e; wd = d;
        req2 = 1'b1; req3 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0; req3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done2) begin dc2 = (dc2 < 0) ? k : 99; x2 = exc2; r2 = rd2; end
            if (done3) begin dc3 = (dc3 < 0) ? k : 99; x3 = exc3; r3 = rd3; end
            if (busy2) bc2++;
            if (busy3) bc3++;
        end
        want2 = (!w && !ex) ? er : rd_last2;
        want3 = (!w && !ex) ? er : rd_last3;
        chk({nm, " done_cycle_L2"}, 32'(dc2), ex ? 32'd1 : 32'd2);
        chk({nm, " done_cycle_L3"}, 32'(dc3), ex ? 32'd1 : 32'd3);
        chk({nm, " exc_L2"}, {31'd0, x2}, {31'd0, ex});
        chk({nm, " exc_L3"}, {31'd0, x3}, {31'd0, ex});
        chk({nm, " busy_cycles_L2"}, 32'(bc2), ex ? 32'd0 : 32'd1);
        chk({nm, " busy_cycles_L3"}, 32'(bc3), ex ? 32'd0 : 32'd2);
        chk({nm, " rd_L2"}, r2, want2);
        chk({nm, " rd_L3"}, r3, want3);
        rd_last2 = want2;
        rd_last3 = want3;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;

        //            w     addr         sz     e     wd             exc   rd
        tbl[0]  = '{1'b1, 32'h10,   2'd2, 1'b0, 32'h1122_3344, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h12,   2'd0, 1'b0, 32'hFFFF_FFAB, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         1'b0, 32'h11AB_3344};
        tbl[3]  = '{1'b1, 32'h10,   2'd2, 1'b0, 32'h80FF_7F01, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h13,   2'd0, 1'b1, 32'h0,         1'b0, 32'hFFFF_FF80};
        tbl[5]  = '{1'b0, 32'h13,   2'd0, 1'b0, 32'h0,         1'b0, 32'h0000_0080};
        tbl[6]  = '{1'b0, 32'h12,   2'd1, 1'b1, 32'h0,         1'b0, 32'hFFFF_80FF};
        tbl[7]  = '{1'b0, 32'h10,   2'd1, 1'b0, 32'h0,         1'b0, 32'h0000_7F01};
        tbl[8]  = '{1'b0, 32'h11,   2'd2, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b1, 32'h13,   2'd1, 1'b0, 32'h0000_DEAD, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h10,   2'd3, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h4000, 2'd2, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b1, 32'h14,   2'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 32'h16,   2'd1, 1'b0, 32'hABCD_1234, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 32'h14,   2'd0, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 32'h14,   2'd2, 1'b0, 32'h0,         1'b0, 32'h1234_FF00};
        tbl[16] = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         1'b0, 32'h80FF_7F01};
        tbl[17] = '{1'b0, 32'h12,   2'd0, 1'b1, 32'h0,         1'b0, 32'hFFFF_FFFF};
        tbl[18] = '{1'b1, 32'h4010, 2'd2, 1'b0, 32'hDEAD_DEAD, 1'b1, 32'h0};
        tbl[19] = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,         1'b0, 32'h80FF_7F01};

        h_addr[0] = 32'h10; h_size[0] = 2'd2; h_ext[0] = 1'b0; h_rd[0] = 32'h80FF_7F01;
        h_addr[1] = 32'h13; h_size[1] = 2'd0; h_ext[1] = 1'b0; h_rd[1] = 32'h0000_0080;
        h_addr[2] = 32'h12; h_size[2] = 2'd1; h_ext[2] = 1'b1; h_rd[2] = 32'hFFFF_80FF;
        h_addr[3] = 32'h10; h_size[3] = 2'd1; h_ext[3] = 1'b0; h_rd[3] = 32'h0000_7F01;

        // Reset, then five idle cycles with everything quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle busy/done/exc L2", {29'd0, busy2, done2, exc2}, 32'd0);
            chk("idle busy/done/exc L3", {29'd0, busy3, done3, exc3}, 32'd0);
            chk("idle rd L2", rd2, 32'd0);
            chk("idle rd L3", rd3, 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            model_op(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].e, tbl[i].d, m_x, m_r);
            do_op(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].x, tbl[i].r,
                  $sformatf("vec%0d", i));
        end

        // LATENCY=3 instance with req held for four loads, dropped in first WAIT cycles.
        @(negedge clk);
        wr = 1'b0; wd = '0;
        addr = h_addr[0]; size = h_size[0]; ext = h_ext[0];
        req3 = 1'b1;
        dones = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("held done k%0d", k), {31'd0, done3}, {31'd0, (k % 3 == 0) && k <= 12});
            chk($sformatf("held busy k%0d", k), {31'd0, busy3}, {31'd0, (k % 3 != 0) && k < 12});
            if (done3) begin
                if (dones < 4) begin
                    chk($sformatf("held rd %0d", dones), rd3, h_rd[dones]);
                    chk($sformatf("held exc %0d", dones), {31'd0, exc3}, 32'd0);
                end
                dones++;
            end
            if (k % 3 == 1) begin
                req3 = 1'b0;
            end else if (k % 3 == 2) begin
                if ((k + 1) / 3 < 4) begin
                    addr = h_addr[(k + 1) / 3];
                    size = h_size[(k + 1) / 3];
                    ext  = h_ext[(k + 1) / 3];
                    req3 = 1'b1;
                end else begin
                    req3 = 1'b0;
                end
            end
        end
        chk("held done count", 32'(dones), 32'd4);
        rd_last3 = h_rd[3];

        // Reset during WAIT of a store aborts it.
        model_op(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFE_F00D, m_x, m_r);
        do_op(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0, "sw20");
        @(negedge clk);
        wr = 1'b1; addr = 32'h20; size = 2'd2; wd = 32'h1234_5678;
        req2 = 1'b1; req3 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0; req3 = 1'b0;
        @(negedge clk);
        chk("abort busy L2", {31'd0, busy2}, 32'd1);
        chk("abort busy L3", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort no done L2 k%0d", k), {31'd0, done2}, 32'd0);
            chk($sformatf("abort no done L3 k%0d", k), {31'd0, done3}, 32'd0);
            @(negedge clk);
        end
        rd_last2 = '0;
        rd_last3 = '0;
        do_op(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, "lw20 after abort");

        // Randomised accesses against the reference model.
        for (int n = 0; n < 80; n++) begin
            r_w = 1'($urandom_range(0, 1));
            r_e = 1'($urandom_range(0, 1));
            r_s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) begin
                if (r_s == 2'd1) r_a[0] = 1'b0;
                if (r_s == 2'd2) r_a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) r_a = r_a | (32'($urandom_range(1, 15)) << 14);
            r_d = $urandom;
            model_op(r_w, r_a, r_s, r_e, r_d, m_x, m_r);
            do_op(r_w, r_a, r_s, r_e, r_d, m_x, m_r, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
